// File: rtl/issue_pkg.sv
// Shared types for the dual-issue scheduler: FSM states, held-slot record, pipe ids.
// Pure declarations and helper functions; no timing and no flow control of its own.
package issue_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        PAIR   = 2'd1,
        SECOND = 2'd2
    } state_t;

    typedef struct packed {
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             rf_write_en;
        logic             mem_op;
        logic             load;
        logic             branch;
    } slot_info_t;

    localparam logic BR_PIPE  = 1'b0;
    localparam logic MEM_PIPE = 1'b1;

    // A load is always a memory-pipe op, even if decode left mem_op clear.
    function automatic logic is_mem(input slot_info_t s);
        return s.mem_op | s.load;
    endfunction

    function automatic logic solo_pipe(input slot_info_t s);
        return is_mem(s) ? MEM_PIPE : BR_PIPE;
    endfunction

endpackage

// File: rtl/issue_hazard_check.sv
// Combinational hazard evaluation on the held pair: load-use per slot, intra-pair RAW/WAW, dual-issue legality.
// Zero latency; no flow control.
module issue_hazard_check
    import issue_pkg::*;
(
    input  slot_info_t       i_slot0,
    input  slot_info_t       i_slot1,
    input  logic             i_v1,
    input  logic             i_ex_load_vld,
    input  logic [REG_W-1:0] i_ex_load_rd,
    output logic [1:0]       o_lu,
    output logic             o_dep,
    output logic             o_dual_ok
);

    logic w_ex_live;
    logic w_rd0_live;
    logic w_struct_ok;

    // x0 never carries a value, so it can never create a load-use or pair dependency.
    assign w_ex_live = i_ex_load_vld && (i_ex_load_rd != '0);

    assign o_lu[0] = w_ex_live &&
                     ((i_slot0.rs1 == i_ex_load_rd) || (i_slot0.rs2 == i_ex_load_rd));
    assign o_lu[1] = w_ex_live &&
                     ((i_slot1.rs1 == i_ex_load_rd) || (i_slot1.rs2 == i_ex_load_rd));

    assign w_rd0_live = i_slot0.rf_write_en && (i_slot0.rd != '0);

    assign o_dep = w_rd0_live &&
                   ((i_slot1.rs1 == i_slot0.rd) ||
                    (i_slot1.rs2 == i_slot0.rd) ||
                    (i_slot1.rf_write_en && (i_slot1.rd == i_slot0.rd)));

    assign w_struct_ok = !(is_mem(i_slot0) && is_mem(i_slot1)) &&
                         !(i_slot0.branch && i_slot1.branch);

    assign o_dual_ok = i_v1 && w_struct_ok && !o_dep && !o_lu[1];

endmodule

// File: rtl/dual_issue_scheduler.sv
// Holds one decoded pair and steers its slots onto the branch and memory pipes, splitting or stalling on hazards.
// Issue decision is combinational on the held pair; decode is back-pressured until the last pending slot issues.
module dual_issue_scheduler
    import issue_pkg::*;
#(
    parameter int REG_ADDR_W = REG_W,
    parameter int CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pair_valid_i,
    output logic                       pair_ready_o,
    input  logic [1:0]                 slot_valid_i,
    input  logic [1:0][REG_ADDR_W-1:0] rs1_i,
    input  logic [1:0][REG_ADDR_W-1:0] rs2_i,
    input  logic [1:0][REG_ADDR_W-1:0] rd_i,
    input  logic [1:0]                 rf_write_en_i,
    input  logic [1:0]                 mem_op_i,
    input  logic [1:0]                 load_i,
    input  logic [1:0]                 branch_i,
    input  logic                       ex_load_valid_i,
    input  logic [REG_ADDR_W-1:0]      ex_load_rd_i,
    input  logic                       flush_i,
    output logic                       br_issue_o,
    output logic                       br_sel_o,
    output logic                       mem_issue_o,
    output logic                       mem_sel_o,
    output logic                       older_in_branch_o,
    output logic [CNT_W-1:0]           split_cnt_o,
    output logic [CNT_W-1:0]           stall_cnt_o
);

    state_t           r_state;
    slot_info_t       r_slot0;
    slot_info_t       r_slot1;
    logic             r_v1;
    logic [CNT_W-1:0] r_split_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    slot_info_t w_in0;
    slot_info_t w_in1;
    logic [1:0] w_lu;
    logic       w_dep;
    logic       w_dual_ok;

    logic   w_br_issue;
    logic   w_br_sel;
    logic   w_mem_issue;
    logic   w_mem_sel;
    logic   w_older_br;
    logic   w_last;
    logic   w_stall;
    logic   w_split;
    state_t w_nxt;
    state_t w_state_d;
    logic   w_pair_ready;
    logic   w_accept;

    always_comb begin
        w_in0 = '{rs1: rs1_i[0], rs2: rs2_i[0], rd: rd_i[0],
                  rf_write_en: rf_write_en_i[0], mem_op: mem_op_i[0],
                  load: load_i[0], branch: branch_i[0]};
        w_in1 = '{rs1: rs1_i[1], rs2: rs2_i[1], rd: rd_i[1],
                  rf_write_en: rf_write_en_i[1], mem_op: mem_op_i[1],
                  load: load_i[1], branch: branch_i[1]};
    end

    issue_hazard_check u_hazard (
        .i_slot0       (r_slot0),
        .i_slot1       (r_slot1),
        .i_v1          (r_v1),
        .i_ex_load_vld (ex_load_valid_i),
        .i_ex_load_rd  (ex_load_rd_i),
        .o_lu          (w_lu),
        .o_dep         (w_dep),
        .o_dual_ok     (w_dual_ok)
    );

    always_comb begin
        w_br_issue  = 1'b0;
        w_br_sel    = 1'b0;
        w_mem_issue = 1'b0;
        w_mem_sel   = 1'b0;
        w_older_br  = 1'b0;
        w_last      = 1'b0;
        w_stall     = 1'b0;
        w_split     = 1'b0;
        w_nxt       = r_state;
        case (r_state)
            PAIR: begin
                if (w_lu[0]) begin
                    w_stall = 1'b1;
                end else if (w_dual_ok) begin
                    w_br_issue  = 1'b1;
                    w_mem_issue = 1'b1;
                    // Slot 0 takes the memory pipe when it must, or when slot 1 needs the branch pipe.
                    if (is_mem(r_slot0) || r_slot1.branch) begin
                        w_mem_sel  = 1'b0;
                        w_br_sel   = 1'b1;
                        w_older_br = 1'b0;
                    end else begin
                        w_br_sel   = 1'b0;
                        w_mem_sel  = 1'b1;
                        w_older_br = 1'b1;
                    end
                    w_last = 1'b1;
                    w_nxt  = EMPTY;
                end else begin
                    if (solo_pipe(r_slot0) == MEM_PIPE) w_mem_issue = 1'b1;
                    else                                w_br_issue  = 1'b1;
                    if (r_v1) begin
                        w_split = 1'b1;
                        w_nxt   = SECOND;
                    end else begin
                        w_last = 1'b1;
                        w_nxt  = EMPTY;
                    end
                end
            end
            SECOND: begin
                if (w_lu[1]) begin
                    w_stall = 1'b1;
                end else begin
                    if (solo_pipe(r_slot1) == MEM_PIPE) begin
                        w_mem_issue = 1'b1;
                        w_mem_sel   = 1'b1;
                    end else begin
                        w_br_issue = 1'b1;
                        w_br_sel   = 1'b1;
                    end
                    w_last = 1'b1;
                    w_nxt  = EMPTY;
                end
            end
            default: ;
        endcase
        if (flush_i) begin
            w_br_issue  = 1'b0;
            w_br_sel    = 1'b0;
            w_mem_issue = 1'b0;
            w_mem_sel   = 1'b0;
            w_older_br  = 1'b0;
            w_last      = 1'b0;
            w_stall     = 1'b0;
            w_split     = 1'b0;
            w_nxt       = EMPTY;
        end
    end

    assign w_pair_ready = !flush_i && ((r_state == EMPTY) || w_last);
    assign w_accept     = pair_valid_i && w_pair_ready;

    // A pair with only slot 1 valid behaves exactly like the SECOND state, so enter it directly.
    always_comb begin
        w_state_d = w_nxt;
        if (w_accept) begin
            case (slot_valid_i)
                2'b00:   w_state_d = EMPTY;
                2'b10:   w_state_d = SECOND;
                default: w_state_d = PAIR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_slot0     <= '0;
            r_slot1     <= '0;
            r_v1        <= 1'b0;
            r_split_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_slot0 <= w_in0;
                r_slot1 <= w_in1;
                r_v1    <= slot_valid_i[1];
            end else if (flush_i) begin
                r_slot0 <= '0;
                r_slot1 <= '0;
                r_v1    <= 1'b0;
            end
            if (w_split && (r_split_cnt != '1)) r_split_cnt <= r_split_cnt + 1'b1;
            if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign pair_ready_o      = w_pair_ready;
    assign br_issue_o        = w_br_issue;
    assign br_sel_o          = w_br_sel;
    assign mem_issue_o       = w_mem_issue;
    assign mem_sel_o         = w_mem_sel;
    assign older_in_branch_o = w_older_br;
    assign split_cnt_o       = r_split_cnt;
    assign stall_cnt_o       = r_stall_cnt;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed bench for dual_issue_scheduler: table of pairs with hand-computed per-cycle routing,
// plus sequences for load-use stall, back-to-back accept, flush, counter saturation and async reset.
module tb_dual_issue_scheduler;

    localparam int RW = 5;
    localparam int CW = 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                pair_valid_i;
    logic                pair_ready_o;
    logic [1:0]          slot_valid_i;
    logic [1:0][RW-1:0]  rs1_i;
    logic [1:0][RW-1:0]  rs2_i;
    logic [1:0][RW-1:0]  rd_i;
    logic [1:0]          rf_write_en_i;
    logic [1:0]          mem_op_i;
    logic [1:0]          load_i;
    logic [1:0]          branch_i;
    logic                ex_load_valid_i;
    logic [RW-1:0]       ex_load_rd_i;
    logic                flush_i;
    logic                br_issue_o;
    logic                br_sel_o;
    logic                mem_issue_o;
    logic                mem_sel_o;
    logic                older_in_branch_o;
    logic [CW-1:0]       split_cnt_o;
    logic [CW-1:0]       stall_cnt_o;

    always #5 clk = ~clk;

    dual_issue_scheduler #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .pair_valid_i      (pair_valid_i),
        .pair_ready_o      (pair_ready_o),
        .slot_valid_i      (slot_valid_i),
        .rs1_i             (rs1_i),
        .rs2_i             (rs2_i),
        .rd_i              (rd_i),
        .rf_write_en_i     (rf_write_en_i),
        .mem_op_i          (mem_op_i),
        .load_i            (load_i),
        .branch_i          (branch_i),
        .ex_load_valid_i   (ex_load_valid_i),
        .ex_load_rd_i      (ex_load_rd_i),
        .flush_i           (flush_i),
        .br_issue_o        (br_issue_o),
        .br_sel_o          (br_sel_o),
        .mem_issue_o       (mem_issue_o),
        .mem_sel_o         (mem_sel_o),
        .older_in_branch_o (older_in_branch_o),
        .split_cnt_o       (split_cnt_o),
        .stall_cnt_o       (stall_cnt_o)
    );

    // {br_issue, br_sel, mem_issue, mem_sel, older_in_branch, pair_ready}
    logic [5:0] obs;
    assign obs = {br_issue_o, br_sel_o, mem_issue_o, mem_sel_o, older_in_branch_o, pair_ready_o};

    typedef struct {
        logic [1:0]    sv;
        logic [RW-1:0] a0, b0, d0, a1, b1, d1;
        logic [1:0]    we, mem, ld, br;
        logic          exv;
        logic [RW-1:0] exrd;
        logic [5:0]    exp0;
        logic [5:0]    exp1;
        int            split;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;
    int exp_split = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] sv,
                                input logic [RW-1:0] a0, b0, d0, a1, b1, d1,
                                input logic [1:0] we, mem, ld, br,
                                input logic exv, input logic [RW-1:0] exrd,
                                input logic [5:0] e0, e1, input int sp);
        vec_t v;
        v.sv = sv; v.a0 = a0; v.b0 = b0; v.d0 = d0; v.a1 = a1; v.b1 = b1; v.d1 = d1;
        v.we = we; v.mem = mem; v.ld = ld; v.br = br; v.exv = exv; v.exrd = exrd;
        v.exp0 = e0; v.exp1 = e1; v.split = sp;
        return v;
    endfunction

    task automatic drive_pair(input vec_t v);
        slot_valid_i  = v.sv;
        rs1_i[0] = v.a0; rs2_i[0] = v.b0; rd_i[0] = v.d0;
        rs1_i[1] = v.a1; rs2_i[1] = v.b1; rd_i[1] = v.d1;
        rf_write_en_i = v.we;
        mem_op_i      = v.mem;
        load_i        = v.ld;
        branch_i      = v.br;
        pair_valid_i  = 1'b1;
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        drive_pair(v);
        ex_load_valid_i = v.exv;
        ex_load_rd_i    = v.exrd;
        @(negedge clk);
        pair_valid_i = 1'b0;
        #1 chk($sformatf("vec%0d_cycle0", idx), 32'(obs), 32'(v.exp0));
        @(negedge clk);
        #1 chk($sformatf("vec%0d_cycle1", idx), 32'(obs), 32'(v.exp1));
        exp_split += v.split;
        chk($sformatf("vec%0d_split_cnt", idx), 32'(split_cnt_o), 32'(exp_split));
        ex_load_valid_i = 1'b0;
        ex_load_rd_i    = '0;
    endtask

    vec_t tbl [14];
    vec_t v_lu;

    initial begin
        // ADD x1 / LW x2,0(x3): no hazard, ALU older to branch pipe.
        tbl[0]  = mk(2'b11, 5,6,1, 3,0,2, 2'b11,2'b10,2'b10,2'b00, 0,0, 6'b101111, 6'b000001, 0);
        // LW x5 / SW x6: two memory ops split.
        tbl[1]  = mk(2'b11, 1,0,5, 2,6,0, 2'b01,2'b11,2'b01,2'b00, 0,0, 6'b001000, 6'b001101, 1);
        // ADD x4,x1,x2 / SUB x7,x4,x3: RAW split.
        tbl[2]  = mk(2'b11, 1,2,4, 4,3,7, 2'b11,2'b00,2'b00,2'b00, 0,0, 6'b100000, 6'b110001, 1);
        // Same with WAW on x4.
        tbl[3]  = mk(2'b11, 1,2,4, 5,3,4, 2'b11,2'b00,2'b00,2'b00, 0,0, 6'b100000, 6'b110001, 1);
        // BEQ / JAL: two branches split.
        tbl[4]  = mk(2'b11, 1,2,0, 0,0,1, 2'b10,2'b00,2'b00,2'b11, 0,0, 6'b100000, 6'b110001, 1);
        // BEQ / LW: branch older to branch pipe.
        tbl[5]  = mk(2'b11, 1,2,0, 4,0,3, 2'b10,2'b10,2'b10,2'b01, 0,0, 6'b101111, 6'b000001, 0);
        // ADD x8 / BEQ: younger branch forces older ALU to memory pipe.
        tbl[6]  = mk(2'b11, 1,2,8, 9,10,0, 2'b01,2'b00,2'b00,2'b10, 0,0, 6'b111001, 6'b000001, 0);
        // Only slot 0 valid.
        tbl[7]  = mk(2'b01, 1,2,3, 0,0,0, 2'b01,2'b00,2'b00,2'b00, 0,0, 6'b100001, 6'b000001, 0);
        // Only slot 1 valid (LW): issues as slot 1 to memory pipe.
        tbl[8]  = mk(2'b10, 0,0,0, 3,0,2, 2'b10,2'b10,2'b10,2'b00, 0,0, 6'b001101, 6'b000001, 0);
        // No slot valid: discarded.
        tbl[9]  = mk(2'b00, 1,2,3, 4,5,6, 2'b11,2'b00,2'b00,2'b00, 0,0, 6'b000001, 6'b000001, 0);
        // Writer to x0 creates no dependency.
        tbl[10] = mk(2'b11, 1,2,0, 0,1,3, 2'b11,2'b00,2'b00,2'b00, 0,0, 6'b101111, 6'b000001, 0);
        // SW / ADD: older memory op takes memory pipe.
        tbl[11] = mk(2'b11, 2,1,0, 4,5,3, 2'b10,2'b01,2'b00,2'b00, 0,0, 6'b111001, 6'b000001, 0);
        // EX load to x0 with reads of x0: no stall.
        tbl[12] = mk(2'b11, 0,0,1, 3,0,2, 2'b11,2'b10,2'b10,2'b00, 1,0, 6'b101111, 6'b000001, 0);
        // EX load to x9 that nobody reads: no stall.
        tbl[13] = mk(2'b11, 5,6,1, 3,0,2, 2'b11,2'b10,2'b10,2'b00, 1,9, 6'b101111, 6'b000001, 0);

        // ADD x1,x9,x2 / LW x3,0(x4): slot 0 load-use on x9.
        v_lu = mk(2'b11, 9,2,1, 4,0,3, 2'b11,2'b10,2'b10,2'b00, 1,9, 6'b000000, 6'b000000, 0);

        rst_n = 1'b0; pair_valid_i = 1'b0; slot_valid_i = '0;
        rs1_i = '0; rs2_i = '0; rd_i = '0;
        rf_write_en_i = '0; mem_op_i = '0; load_i = '0; branch_i = '0;
        ex_load_valid_i = 1'b0; ex_load_rd_i = '0; flush_i = 1'b0;

        #1 chk("reset_outputs", 32'(obs), 32'(6'b000001));
        chk("reset_split_cnt", 32'(split_cnt_o), 32'd0);
        chk("reset_stall_cnt", 32'(stall_cnt_o), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) apply(tbl[i], i);
        chk("table_stall_cnt", 32'(stall_cnt_o), 32'd0);

        // Load-use on slot 0 held two cycles, then released into a dual issue.
        @(negedge clk);
        drive_pair(v_lu);
        ex_load_valid_i = 1'b1; ex_load_rd_i = 5'd9;
        @(negedge clk);
        pair_valid_i = 1'b0;
        #1 chk("lu_hold0", 32'(obs), 32'(6'b000000));
        chk("lu_stall_cnt0", 32'(stall_cnt_o), 32'd0);
        @(negedge clk);
        #1 chk("lu_hold1", 32'(obs), 32'(6'b000000));
        chk("lu_stall_cnt1", 32'(stall_cnt_o), 32'd1);
        @(negedge clk);
        ex_load_valid_i = 1'b0;
        #1 chk("lu_release", 32'(obs), 32'(6'b101111));
        chk("lu_stall_cnt2", 32'(stall_cnt_o), 32'd2);

        // Back-to-back: new pair accepted on the edge that issues slot 1.
        @(negedge clk);
        drive_pair(tbl[1]);
        @(negedge clk);
        pair_valid_i = 1'b0;
        #1 chk("b2b_first", 32'(obs), 32'(6'b001000));
        @(negedge clk);
        #1 chk("b2b_second", 32'(obs), 32'(6'b001101));
        drive_pair(tbl[0]);
        @(negedge clk);
        pair_valid_i = 1'b0;
        #1 chk("b2b_next_pair", 32'(obs), 32'(6'b101111));
        exp_split += 1;
        chk("b2b_split_cnt", 32'(split_cnt_o), 32'(exp_split));

        // Flush in SECOND while decode offers a pair: nothing issued or captured.
        @(negedge clk);
        drive_pair(tbl[1]);
        @(negedge clk);
        pair_valid_i = 1'b0;
        #1 chk("flush_pre", 32'(obs), 32'(6'b001000));
        @(negedge clk);
        drive_pair(tbl[0]);
        flush_i = 1'b1;
        #1 chk("flush_suppress", 32'(obs), 32'(6'b000000));
        @(negedge clk);
        flush_i = 1'b0; pair_valid_i = 1'b0;
        #1 chk("flush_empty", 32'(obs), 32'(6'b000001));
        exp_split += 1;
        chk("flush_split_cnt", 32'(split_cnt_o), 32'(exp_split));
        chk("flush_stall_cnt", 32'(stall_cnt_o), 32'd2);

        // Long load-use hold drives stall_cnt into saturation.
        @(negedge clk);
        drive_pair(v_lu);
        ex_load_valid_i = 1'b1; ex_load_rd_i = 5'd9;
        @(negedge clk);
        pair_valid_i = 1'b0;
        repeat (65540) @(negedge clk);
        #1 chk("sat_stall_cnt", 32'(stall_cnt_o), 32'h0000FFFF);
        chk("sat_outputs", 32'(obs), 32'(6'b000000));
        @(negedge clk);
        #1 chk("sat_hold", 32'(stall_cnt_o), 32'h0000FFFF);

        // Asynchronous reset mid-PAIR.
        rst_n = 1'b0;
        #1 chk("arst_outputs", 32'(obs), 32'(6'b000001));
        chk("arst_stall_cnt", 32'(stall_cnt_o), 32'd0);
        chk("arst_split_cnt", 32'(split_cnt_o), 32'd0);
        ex_load_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_split = 0;
        apply(tbl[0], 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dual_issue_scheduler.md
Name: dual_issue_scheduler

Overview:
- Sequencing controller in front of the dual-pipe issue mux: holds one decoded instruction pair and decides per cycle which slot goes to the branch pipe and which to the memory pipe.
- Resolves structural conflicts (two memory ops, two branches), intra-pair RAW/WAW, and load-use hazards against the memory pipe EX stage by splitting the pair over two cycles or stalling.
- Drives the issue mux selects and back-pressures decode.

Parameters:
- REG_ADDR_W, 5, architectural register index width
- CNT_W, 16, width of saturating performance counters

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- pair_valid_i  in  1  decode offers a pair
- pair_ready_o  out  1  pair accepted on clk edge when pair_valid_i&&pair_ready_o
- slot_valid_i  in  2  per-slot valid; [0] is the older instruction
- rs1_i, rs2_i, rd_i  in  2xREG_ADDR_W  per-slot register indices
- rf_write_en_i  in  2  per-slot register write
- mem_op_i  in  2  per-slot load or store
- load_i  in  2  per-slot load
- branch_i  in  2  per-slot branch/JAL/JALR
- ex_load_valid_i  in  1  memory pipe EX holds a load
- ex_load_rd_i  in  REG_ADDR_W  destination of that load
- flush_i  in  1  mispredict; kill held pair
- br_issue_o  out  1  branch pipe receives an instruction this cycle
- br_sel_o  out  1  slot index routed to branch pipe
- mem_issue_o  out  1  memory pipe receives an instruction this cycle
- mem_sel_o  out  1  slot index routed to memory pipe
- older_in_branch_o  out  1  on dual issue, the older slot is in the branch pipe
- split_cnt_o  out  CNT_W  pairs issued over two cycles
- stall_cnt_o  out  CNT_W  cycles with a held pair and no issue

Behaviour:
- Reset: state EMPTY, held pair cleared, counters 0. All issue outputs and older_in_branch_o are 0 while in EMPTY.
- Held-pair register: captures all *_i slot fields on acceptance. All decisions use held values, never live inputs.
- States:
  - EMPTY: no pending slot.
  - PAIR: held slots with valid bits v0/v1 pending.
  - SECOND: only slot 1 pending.
- Pipe class per slot:
  - mem_op → memory pipe.
  - branch → branch pipe.
  - neither (ALU) → either pipe.
- lu(s): ex_load_valid_i && ex_load_rd_i!=0 && (rs1[s]==ex_load_rd_i || rs2[s]==ex_load_rd_i).
- dep: rf_write_en[0] && rd[0]!=0, and any of rs1[1]==rd[0], rs2[1]==rd[0], (rf_write_en[1] && rd[1]==rd[0]).
- PAIR, v0=1:
  - lu(0): issue nothing, stay in PAIR, stall_cnt++.
  - Dual issue when all hold: v1, !(mem_op[0]&&mem_op[1]), !(branch[0]&&branch[1]), !dep, !lu(1).
    - If mem_op[0] or branch[1]: mem_sel=0, br_sel=1, older_in_branch=0.
    - Otherwise: br_sel=0, mem_sel=1, older_in_branch=1.
    - Go to EMPTY.
  - Otherwise slot 0 issues alone (memory pipe if mem_op[0], else branch pipe). Go to SECOND if v1, else EMPTY. split_cnt++ if v1.
- PAIR with v0=0, v1=1: handled exactly as SECOND.
- SECOND:
  - lu(1): stall, stall_cnt++.
  - Otherwise slot 1 issues (memory pipe if mem_op[1], else branch pipe) and goes to EMPTY.
- A pair with slot_valid_i==0 is accepted and discarded (state stays EMPTY).
- pair_ready_o = !flush_i && (EMPTY || the last pending slot issues this cycle). Back-to-back pairs need no bubble; the new pair enters PAIR on the same edge.
- flush_i: same-cycle combinational suppression of all issue outputs. Next state EMPTY, held pair invalidated, no counter increments; flush overrides accept.
- Counters saturate at all-ones and never wrap.
- rst_n assertion mid-operation: immediate return to reset values, no partial issue.

Decomposition:
- Shared package issue_pkg:
  - state enum {EMPTY, PAIR, SECOND}
  - slot_info_t struct {rs1, rs2, rd, rf_write_en, mem_op, load, branch}
  - BR_PIPE/MEM_PIPE constants
- One sub-module: issue_hazard_check (combinational lu/dep/structural evaluation on held pair), instantiated once.

Test Plan:
- Pair (ADD x1 / LW x2, 0(x3)), no hazards → same cycle br_issue=1 br_sel=0, mem_issue=1 mem_sel=1, older_in_branch=1, pair_ready=1, split_cnt stays 0.
- Pair (LW x5 / SW x6) → cycle0 mem_sel=0 only, state SECOND, pair_ready=0. Cycle1 mem_sel=1 only, pair_ready=1. split_cnt=1.
- Pair (ADD x4,x1,x2 / SUB x7,x4,x3) → RAW split: slot0 to branch pipe cycle0, slot1 cycle1. Repeat with rd[1]=4 (WAW) → also split.
- ex_load_valid=1, ex_load_rd=9, slot0 reads x9, held for 2 cycles → no issue for 2 cycles, stall_cnt=2, then dual issue. With ex_load_rd=0 → no stall.
- flush_i asserted in SECOND with pair_valid=1 → no issue that cycle, pair_ready=0, next state EMPTY, pair not captured.
- Preload stall_cnt to 0xFFFF via a long load-use hold → stays at 0xFFFF. rst_n low mid-PAIR → outputs 0, counters 0 asynchronously.
